// File: rtl/work_cmd_pkg.sv
// Shared constants and types for the work command core: register map,
// control FSM states, status-word field positions and the "no nonce" marker.
package work_cmd_pkg;

    localparam logic [3:0] ADDR_VERSION = 4'h0;
    localparam logic [3:0] ADDR_NONCE   = 4'h1;
    localparam logic [3:0] ADDR_STATUS  = 4'h2;
    localparam logic [3:0] ADDR_LATCH   = 4'hF;

    localparam logic [31:0] INVALID_NONCE = 32'hFFFF_FFFF;

    // status word: {err_cnt[7:0], overflow, 3'b0, channels-1[3:0], count[8:0], last_pop_chan[3:0], 3'b0}
    localparam int STAT_ERR_LSB = 24;
    localparam int STAT_OVF_BIT = 23;
    localparam int STAT_CHN_LSB = 16;
    localparam int STAT_CNT_LSB = 7;
    localparam int STAT_LPC_LSB = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } cmd_state_e;

endpackage

// File: rtl/work_cmd_core_fifo.sv
// nonce_sync_fifo: single-clock FIFO with occupancy count. A push into a full
// FIFO is accepted only when a pop happens in the same cycle; a pop on an
// empty FIFO is ignored, so an empty-FIFO push still lands.
module nonce_sync_fifo #(
    parameter  int WIDTH = 34,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // storage array; contents need no reset because count gates every read
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // pointers and occupancy
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/work_cmd_core.sv
// work_cmd_core: parity-checked host register commands, per-channel job
// staging with atomic latch, and a golden-nonce FIFO read back over the
// command port.
// Build option: define NONCE_FILTER_EN to drop 0xFFFFFFFF nonces and
// nonces repeating the last stored nonce of the same channel.
module work_cmd_core
    import work_cmd_pkg::*;
#(
    parameter  logic [31:0] VERSION    = 32'd2,
    parameter  int          CHANNELS   = 4,
    parameter  int          FIFO_DEPTH = 16,
    localparam int          CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int          CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [37+CH_W:0]        cmd_word,
    output logic                    rsp_valid,
    output logic [31:0]             rsp_data,
    input  logic                    nonce_valid,
    input  logic [CH_W-1:0]         nonce_chan,
    input  logic [31:0]             nonce,
    output logic [CHANNELS*256-1:0] job_midstate,
    output logic [CHANNELS*256-1:0] job_data,
    output logic [CHANNELS-1:0]     new_work
);

    cmd_state_e state;
    cmd_state_e state_nxt;

    logic [31:0]     cmd_data;
    logic [3:0]      cmd_addr;
    logic [CH_W-1:0] cmd_chan;
    logic            cmd_we;
    logic            cmd_acc;
    logic            cmd_ok;
    logic            cmd_bad;
    logic            wr_acc;
    logic            rd_acc;

    logic [255:0]    stg_mid [CHANNELS];
    logic [223:0]    stg_dat [CHANNELS];

    logic [7:0]      err_cnt;
    logic            overflow;
    logic [3:0]      last_pop_chan;
    logic [31:0]     status_word;
    logic [31:0]     rsp_nxt;

    logic            nonce_pass;
    logic            push_req;
    logic            push_store;
    logic            pop_req;
    logic            ovf_evt;
    logic [31+CH_W:0] fifo_rd;
    logic [CNT_W-1:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    assign cmd_data = cmd_word[31:0];
    assign cmd_addr = cmd_word[35:32];
    assign cmd_chan = cmd_word[36 +: CH_W];
    assign cmd_we   = cmd_word[36+CH_W];

    assign cmd_ready = (state == ST_IDLE) && rst_n;
    assign cmd_acc   = cmd_valid && cmd_ready;
    assign cmd_ok    = cmd_acc && !(^cmd_word) && (32'(cmd_chan) < CHANNELS);
    assign cmd_bad   = cmd_acc && !cmd_ok;
    assign wr_acc    = cmd_ok && cmd_we;
    assign rd_acc    = cmd_ok && !cmd_we;

    assign pop_req    = rd_acc && (cmd_addr == ADDR_NONCE);
    assign push_req   = nonce_valid && nonce_pass;
    assign push_store = push_req && (!fifo_full || pop_req);
    assign ovf_evt    = push_req && fifo_full && !pop_req;

    // control state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next state and response strobe; a read spends one cycle in RESP
    always_comb begin
        state_nxt = state;
        rsp_valid = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_acc) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = rst_n;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // status word assembly
    always_comb begin
        status_word                        = '0;
        status_word[STAT_ERR_LSB +: 8]     = err_cnt;
        status_word[STAT_OVF_BIT]          = overflow;
        status_word[STAT_CHN_LSB +: 4]     = 4'(CHANNELS - 1);
        status_word[STAT_CNT_LSB +: 9]     = 9'(fifo_count);
        status_word[STAT_LPC_LSB +: 4]     = last_pop_chan;
    end

    // read mux, evaluated in the accept cycle and registered into rsp_data
    always_comb begin
        rsp_nxt = INVALID_NONCE;
        case (cmd_addr)
            ADDR_VERSION: rsp_nxt = VERSION;
            ADDR_NONCE:   rsp_nxt = fifo_empty ? INVALID_NONCE : fifo_rd[31:0];
            ADDR_STATUS:  rsp_nxt = status_word;
            default:      rsp_nxt = INVALID_NONCE;
        endcase
    end

    // error counter, sticky overflow, response data and last popped channel
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_cnt       <= '0;
            overflow      <= 1'b0;
            rsp_data      <= '0;
            last_pop_chan <= '0;
        end else begin
            if (wr_acc && (cmd_addr == ADDR_STATUS)) begin
                err_cnt  <= '0;
                overflow <= 1'b0;
            end else if (cmd_bad && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 1'b1;
            end
            // an overflow in the same cycle as a clear must not be lost
            if (ovf_evt) begin
                overflow <= 1'b1;
            end
            if (rd_acc) begin
                rsp_data <= rsp_nxt;
            end
            if (pop_req && !fifo_empty) begin
                last_pop_chan <= 4'(fifo_rd[32 +: CH_W]);
            end
        end
    end

    // per-channel staging writes and atomic job latch; address 0x2 is the
    // clear command, so it never reaches midstate staging word 2
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                stg_mid[c] <= '0;
                stg_dat[c] <= '0;
            end
            job_midstate <= '0;
            job_data     <= '0;
            new_work     <= '0;
        end else begin
            new_work <= '0;
            for (int c = 0; c < CHANNELS; c++) begin
                if (wr_acc && (cmd_chan == CH_W'(c))) begin
                    if (cmd_addr == ADDR_LATCH) begin
                        job_midstate[c*256 +: 256] <= stg_mid[c];
                        job_data[c*256 +: 256]     <= {cmd_data, stg_dat[c]};
                        new_work[c]                <= 1'b1;
                    end else if (cmd_addr[3]) begin
                        stg_dat[c][cmd_addr[2:0]*32 +: 32] <= cmd_data;
                    end else if (cmd_addr != ADDR_STATUS) begin
                        stg_mid[c][cmd_addr[2:0]*32 +: 32] <= cmd_data;
                    end
                end
            end
        end
    end

`ifdef NONCE_FILTER_EN
    logic [31:0] last_nonce [CHANNELS];
    logic        dup_hit;

    // repeat detection against the last stored nonce of the source channel
    always_comb begin
        dup_hit = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if ((nonce_chan == CH_W'(c)) && (nonce == last_nonce[c])) begin
                dup_hit = 1'b1;
            end
        end
    end

    assign nonce_pass = (nonce != INVALID_NONCE) && !dup_hit;

    // remember the nonce each channel last got into the FIFO
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                last_nonce[c] <= INVALID_NONCE;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (push_store && (nonce_chan == CH_W'(c))) begin
                    last_nonce[c] <= nonce;
                end
            end
        end
    end
`else
    assign nonce_pass = 1'b1;
`endif

    nonce_sync_fifo #(
        .WIDTH (32 + CH_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push_req),
        .wr_data ({nonce_chan, nonce}),
        .pop     (pop_req),
        .rd_data (fifo_rd),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_work_cmd_core.sv
// Bench for work_cmd_core. Five channels are used so that a 3-bit chan
// field exists and chan=5 is a genuinely out-of-range channel.
module tb_work_cmd_core;

    localparam int N_CH  = 5;
    localparam int DEPTH = 16;
    localparam int WW    = 41;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WW-1:0]        cmd_word;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic                 nonce_valid;
    logic [2:0]           nonce_chan;
    logic [31:0]          nonce;
    logic [N_CH*256-1:0]  job_midstate;
    logic [N_CH*256-1:0]  job_data;
    logic [N_CH-1:0]      new_work;

    work_cmd_core #(
        .VERSION    (32'd2),
        .CHANNELS   (N_CH),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_word     (cmd_word),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .nonce_valid  (nonce_valid),
        .nonce_chan   (nonce_chan),
        .nonce        (nonce),
        .job_midstate (job_midstate),
        .job_data     (job_data),
        .new_work     (new_work)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;

    // reference model state
    logic [31:0] m_stg_mid [N_CH][8];
    logic [31:0] m_stg_dat [N_CH][7];
    logic [31:0] m_job_mid [N_CH][8];
    logic [31:0] m_job_dat [N_CH][8];
    logic [34:0] m_q [$];
    int          m_err;
    bit          m_ovf;
    int          m_lpc;
    bit          m_busy;
`ifdef NONCE_FILTER_EN
    logic [31:0] m_last [N_CH];
`endif

    logic [31:0] last_rsp;
    logic [31:0] pushed_n [17];
    int          pushed_c [17];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [WW-1:0] mk(input bit we, input int ch, input int ad,
                                         input logic [31:0] d, input bit bad);
        logic [WW-2:0] body;
        body = {we, 3'(ch), 4'(ad), d};
        return {(^body) ^ bad, body};
    endfunction

    function automatic logic [31:0] model_status();
        return (32'(m_err) << 24) | (32'(m_ovf) << 23) | (32'(N_CH - 1) << 16) |
               (32'(m_q.size()) << 7) | (32'(m_lpc) << 3);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < 8; k++) begin
                m_stg_mid[c][k] = '0;
                m_job_mid[c][k] = '0;
                m_job_dat[c][k] = '0;
            end
            for (int k = 0; k < 7; k++) m_stg_dat[c][k] = '0;
`ifdef NONCE_FILTER_EN
            m_last[c] = 32'hFFFF_FFFF;
`endif
        end
        m_q.delete();
        m_err  = 0;
        m_ovf  = 1'b0;
        m_lpc  = 0;
        m_busy = 1'b0;
    endtask

    // one clock cycle: drive, advance the model, step, compare
    task automatic do_cycle(input bit cv, input logic [WW-1:0] w, input bit nv,
                            input logic [2:0] nch, input logic [31:0] nn);
        bit          acc, exp_v, keep;
        logic [31:0] exp_d, dat;
        logic [4:0]  exp_nw;
        logic [34:0] e;
        int          ch, ad, rc, rw;
        cmd_valid   = cv;
        cmd_word    = w;
        nonce_valid = nv;
        nonce_chan  = nch;
        nonce       = nn;
        chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy));
        acc    = cv && !m_busy;
        exp_v  = 1'b0;
        exp_d  = '0;
        exp_nw = '0;
        ch  = int'(w[38:36]);
        ad  = int'(w[35:32]);
        dat = w[31:0];
        if (acc) begin
            if ((^w) != 1'b0 || ch >= N_CH) begin
                m_err = (m_err < 255) ? m_err + 1 : 255;
            end else if (w[39]) begin
                if (ad == 2) begin
                    m_err = 0;
                    m_ovf = 1'b0;
                end else if (ad < 8) begin
                    m_stg_mid[ch][ad] = dat;
                end else if (ad < 15) begin
                    m_stg_dat[ch][ad-8] = dat;
                end else begin
                    for (int k = 0; k < 8; k++) m_job_mid[ch][k] = m_stg_mid[ch][k];
                    for (int k = 0; k < 7; k++) m_job_dat[ch][k] = m_stg_dat[ch][k];
                    m_job_dat[ch][7] = dat;
                    exp_nw[ch] = 1'b1;
                end
            end else begin
                exp_v = 1'b1;
                case (ad)
                    0: exp_d = 32'd2;
                    1: begin
                        if (m_q.size() == 0) begin
                            exp_d = 32'hFFFF_FFFF;
                        end else begin
                            e     = m_q.pop_front();
                            exp_d = e[31:0];
                            m_lpc = int'(e[34:32]);
                        end
                    end
                    2: exp_d = model_status();
                    default: exp_d = 32'hFFFF_FFFF;
                endcase
            end
        end
        m_busy = exp_v;
        if (nv) begin
            keep = 1'b1;
`ifdef NONCE_FILTER_EN
            if (nn == 32'hFFFF_FFFF || m_last[int'(nch)] == nn) keep = 1'b0;
`endif
            if (keep) begin
                if (m_q.size() < DEPTH) begin
                    m_q.push_back({nch, nn});
`ifdef NONCE_FILTER_EN
                    m_last[int'(nch)] = nn;
`endif
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        if (exp_v) begin
            chk("rsp_data", rsp_data, exp_d);
            last_rsp = rsp_data;
        end
        chk("new_work", 32'(new_work), 32'(exp_nw));
        rc = $urandom_range(0, N_CH - 1);
        rw = $urandom_range(0, 7);
        chk("job_mid", job_midstate[rc*256 + rw*32 +: 32], m_job_mid[rc][rw]);
        chk("job_dat", job_data[rc*256 + rw*32 +: 32], m_job_dat[rc][rw]);
    endtask

    task automatic idle();
        do_cycle(1'b0, '0, 1'b0, 3'd0, 32'd0);
    endtask

    task automatic send(input bit we, input int ch, input int ad, input logic [31:0] d);
        if (m_busy) idle();
        do_cycle(1'b1, mk(we, ch, ad, d, 1'b0), 1'b0, 3'd0, 32'd0);
    endtask

    task automatic push_n(input int ch, input logic [31:0] n);
        do_cycle(1'b0, '0, 1'b1, 3'(ch), n);
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        cmd_valid   = 1'b0;
        cmd_word    = '0;
        nonce_valid = 1'b0;
        nonce_chan  = '0;
        nonce       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_data", rsp_data, 32'd0);
        chk("rst_new_work", 32'(new_work), 32'd0);
        for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < 8; k++) begin
                chk("rst_job_mid", job_midstate[c*256 + k*32 +: 32], 32'd0);
                chk("rst_job_dat", job_data[c*256 + k*32 +: 32], 32'd0);
            end
        end
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("ready_after_rst", 32'(cmd_ready), 32'd1);
    endtask

    int          i_ch, i_ad;
    bit          i_cv, i_we, i_bad, i_nv;
    logic [31:0] i_d;

    initial begin
        last_rsp = '0;
        do_reset();

        // version and empty-FIFO reads
        send(1'b0, 0, 0, 32'd0);
        chk("version", last_rsp, 32'h0000_0002);
        send(1'b0, 0, 1, 32'd0);
        chk("empty_pop", last_rsp, 32'hFFFF_FFFF);
        send(1'b0, 0, 5, 32'd0);
        chk("unmapped_read", last_rsp, 32'hFFFF_FFFF);

        // stage and latch channel 2
        for (int a = 0; a < 15; a++) send(1'b1, 2, a, 32'h0200_0000 + 32'(a));
        send(1'b1, 2, 15, 32'hDEAD_BEEF);
        chk("latch_new_work", 32'(new_work), 32'h4);
        chk("latch_top_word", job_data[2*256+224 +: 32], 32'hDEAD_BEEF);
        chk("latch_dat0", job_data[2*256 +: 32], 32'h0200_0008);
        chk("latch_mid7", job_midstate[2*256+224 +: 32], 32'h0200_0007);
        for (int c = 0; c < N_CH; c++) begin
            if (c != 2) begin
                for (int k = 0; k < 8; k++) begin
                    chk("other_ch_mid", job_midstate[c*256 + k*32 +: 32], 32'd0);
                    chk("other_ch_dat", job_data[c*256 + k*32 +: 32], 32'd0);
                end
            end
        end
        idle();
        chk("new_work_once", 32'(new_work), 32'd0);

        // dropped words: bad parity, then out-of-range channel
        do_cycle(1'b1, mk(1'b1, 1, 0, 32'h1111_1111, 1'b1), 1'b0, 3'd0, 32'd0);
        do_cycle(1'b1, mk(1'b1, 5, 0, 32'h2222_2222, 1'b0), 1'b0, 3'd0, 32'd0);
        send(1'b1, 1, 15, 32'd0);
        chk("dropped_no_stage", job_midstate[1*256 +: 32], 32'd0);
        send(1'b0, 0, 2, 32'd0);
        chk("err_cnt_2", (last_rsp >> 24) & 32'hFF, 32'd2);
        chk("status_chans", (last_rsp >> 16) & 32'hF, 32'd4);
        send(1'b1, 0, 2, 32'hFFFF_FFFF);
        send(1'b0, 0, 2, 32'd0);
        chk("err_cleared", (last_rsp >> 24) & 32'hFF, 32'd0);

        // err_cnt saturation
        for (int k = 0; k < 260; k++) do_cycle(1'b1, mk(1'b1, 0, 3, 32'd0, 1'b1), 1'b0, 3'd0, 32'd0);
        send(1'b0, 0, 2, 32'd0);
        chk("err_sat", (last_rsp >> 24) & 32'hFF, 32'hFF);
        send(1'b1, 0, 2, 32'd0);

        // 17 pushes into a 16-deep FIFO
        for (int k = 0; k < 17; k++) begin
            pushed_n[k] = $urandom & 32'h7FFF_FFFF;
            pushed_c[k] = $urandom_range(0, N_CH - 1);
            push_n(pushed_c[k], pushed_n[k]);
        end
        send(1'b0, 0, 2, 32'd0);
        chk("full_count", (last_rsp >> 7) & 32'h1FF, 32'd16);
        chk("full_ovf", (last_rsp >> 23) & 32'h1, 32'd1);
        for (int k = 0; k < 16; k++) begin
            send(1'b0, 0, 1, 32'd0);
            chk("pop_order", last_rsp, pushed_n[k]);
            send(1'b0, 0, 2, 32'd0);
            chk("pop_chan", (last_rsp >> 3) & 32'hF, 32'(pushed_c[k]));
        end
        send(1'b0, 0, 1, 32'd0);
        chk("pop_17th", last_rsp, 32'hFFFF_FFFF);

        // full FIFO with simultaneous push and pop
        send(1'b1, 0, 2, 32'd0);
        for (int k = 0; k < 16; k++) push_n(k % N_CH, 32'h5000_0000 + 32'(k));
        if (m_busy) idle();
        do_cycle(1'b1, mk(1'b0, 0, 1, 32'd0, 1'b0), 1'b1, 3'd1, 32'hA5A5_0001);
        chk("fullpop_oldest", last_rsp, 32'h5000_0000);
        send(1'b0, 0, 2, 32'd0);
        chk("fullpop_count", (last_rsp >> 7) & 32'h1FF, 32'd16);
        chk("fullpop_ovf", (last_rsp >> 23) & 32'h1, 32'd0);

        // empty FIFO with simultaneous push and pop
        for (int k = 0; k < 20 && m_q.size() > 0; k++) send(1'b0, 0, 1, 32'd0);
        if (m_busy) idle();
        do_cycle(1'b1, mk(1'b0, 0, 1, 32'd0, 1'b0), 1'b1, 3'd3, 32'h0BAD_CAFE);
        chk("emptypop_rsp", last_rsp, 32'hFFFF_FFFF);
        send(1'b0, 0, 1, 32'd0);
        chk("emptypop_stored", last_rsp, 32'h0BAD_CAFE);

        // invalid and repeated nonces
        send(1'b1, 0, 2, 32'd0);
        push_n(0, 32'hFFFF_FFFF);
        push_n(0, 32'h1234_5678);
        push_n(0, 32'h1234_5678);
        send(1'b0, 0, 2, 32'd0);
`ifdef NONCE_FILTER_EN
        chk("filter_count", (last_rsp >> 7) & 32'h1FF, 32'd1);
`else
        chk("filter_count", (last_rsp >> 7) & 32'h1FF, 32'd3);
`endif

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            i_cv  = 1'($urandom_range(0, 1));
            i_we  = 1'($urandom_range(0, 1));
            i_ch  = ($urandom_range(0, 9) == 0) ? $urandom_range(5, 7) : $urandom_range(0, N_CH - 1);
            i_ad  = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(0, 15);
            i_bad = ($urandom_range(0, 15) == 0);
            i_d   = $urandom;
            i_nv  = ($urandom_range(0, 2) == 0);
            do_cycle(i_cv, mk(i_we, i_ch, i_ad, i_d, i_bad), i_nv,
                     3'($urandom_range(0, N_CH - 1)), $urandom);
        end
        send(1'b0, 0, 2, 32'd0);

        // reset during the response cycle
        if (m_busy) idle();
        cmd_valid = 1'b1;
        cmd_word  = mk(1'b0, 0, 0, 32'd0, 1'b0);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("abort_cmd_ready", 32'(cmd_ready), 32'd0);
        @(posedge clk);
        #1;
        chk("abort_rsp_valid2", 32'(rsp_valid), 32'd0);
        chk("abort_rsp_data", rsp_data, 32'd0);
        rst_n = 1'b1;
        model_reset();
        #1;
        chk("abort_ready", 32'(cmd_ready), 32'd1);
        send(1'b0, 0, 2, 32'd0);
        chk("abort_status", last_rsp, 32'h0004_0000);
        idle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
